rf_wport_arbiter: RTL
=====================

// Module: rf_wport_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline writeback and the long-latency unit (LU, e.g. mul/div).
//  Pipeline writeback has priority; LU results are buffered in a DEPTH-entry FIFO and drained into free write-port slots.
//  An age counter prevents starvation: a stalled FIFO head forces a one-cycle pipeline stall to claim the port.
//  Sits between the WB stage outputs and the RF write port.
// PARAMETERS
//  N         32  data width
//  DEPTH     2   LU result FIFO entries; power of 2, >= 2
//  MAX_WAIT  4   cycles the FIFO head may wait before a forced drain; >= 1
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  pipe_wr_en   in   1  WB stage write request
//  pipe_rd      in   5  WB stage destination register
//  pipe_data    in   N  WB stage write data
//  lu_valid     in   1  LU result valid
//  lu_rd        in   5  LU destination register
//  lu_data      in   N  LU result data
//  lu_ready     out  1  FIFO can accept; transfer on lu_valid & lu_ready at clk edge
//  stall_req    out  1  registered; freezes MEM/WB, and WB replays its write next cycle
//  rf_wr_en     out  1  RF write enable, combinational
//  rf_rd        out  5  RF write address
//  rf_data      out  N  RF write data
//  fifo_cnt     out  $clog2(DEPTH)+1  occupancy, debug
// BEHAVIOUR
//  Reset:
//  - cnt=0, rd/wr ptr=0, age=0, state=EMPTY, stall_req=0.
//  - While rst=1: rf_wr_en=0, lu_ready=0.
//  Effective pipeline request: pw = pipe_wr_en & (pipe_rd!=0) & ~stall_req.
//  Grant, combinational, same cycle:
//  - stall_req=1 and FIFO non-empty: grant FIFO head.
//  - else pw=1: grant pipeline. Zero latency; rf_* = pipe_*.
//  - else FIFO non-empty: grant FIFO head; pop at edge.
//  - else rf_wr_en=0; rf_rd and rf_data are don't-care (drive 0).
//  LU enqueue:
//  - lu_ready = (cnt < DEPTH). No bypass: lu_ready stays 0 when full even if a pop occurs.
//  - Accepted entry with lu_rd==0 is discarded; not stored, cnt unchanged.
//  - Earliest RF write of an accepted LU result is one cycle after acceptance.
//  - Simultaneous push and pop: cnt unchanged; pointers wrap modulo DEPTH.
//  Age counter, width $clog2(MAX_WAIT+1):
//  - Cleared on pop or when FIFO is empty.
//  - Otherwise +1 per cycle the head is present and not granted; saturates at MAX_WAIT.
//  FSM (stall_req = state==FORCE):
//  - EMPTY: cnt becomes >0 -> PEND.
//  - PEND: pop empties FIFO -> EMPTY; else head not granted and age==MAX_WAIT-1 at edge -> FORCE.
//  - FORCE: always pops head. Exactly one cycle. -> EMPTY if FIFO now empty, else PEND with age=0.
//  - During FORCE, pipe_wr_en is ignored for this cycle; the pipeline holds MEM/WB and presents the same write next cycle.
//  Ordering:
//  - FIFO drains in arrival order.
//  - WAW between LU and pipeline to the same rd is prevented by issue logic, not here.
//  - rst mid-operation drops all FIFO contents.
// TESTING
//  1 Pipe only: pipe_wr_en=1, rd=5, data=0xA5 -> same cycle rf_wr_en=1, rf_rd=5, rf_data=0xA5; stall_req stays 0.
//  2 LU into idle port: lu_valid=1, rd=7, data=0x1234 accepted at edge t -> cycle t+1 rf_wr_en=1, rf_rd=7; fifo_cnt 1 -> 0.
//  3 Starvation, MAX_WAIT=4: pipe_wr_en=1 continuously with one LU entry queued -> stall_req=1 on the 5th cycle after enqueue;
//    that cycle writes the LU entry. Next cycle the pipeline write replays and stall_req=0.
//  4 Full FIFO, DEPTH=2: 3 back-to-back LU results while pipe busy -> lu_ready=0 after two accepts, 3rd held; pop makes lu_ready=1 next cycle.
//  5 x0 filtering: lu_rd=0 accepted -> fifo_cnt unchanged. pipe_rd=0 with pipe_wr_en=1 -> slot given to FIFO head if present.
//  6 Reset mid-drain: rst=1 with cnt=2, state FORCE -> next cycle cnt=0, stall_req=0, rf_wr_en=0, lu_ready=0 while rst held.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results are queued in a small FIFO and drained into idle slots, with forced drain on starvation.
module rf_wport_arbiter #(
  parameter int N        = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_wr_en,
  input  logic [4:0]               pipe_rd,
  input  logic [N-1:0]             pipe_data,
  input  logic                     lu_valid,
  input  logic [4:0]               lu_rd,
  input  logic [N-1:0]             lu_data,
  output logic                     lu_ready,
  output logic                     stall_req,
  output logic                     rf_wr_en,
  output logic [4:0]               rf_rd,
  output logic [N-1:0]             rf_data,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_TRIG = AGE_W'(MAX_WAIT - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(MAX_WAIT);

  typedef enum logic [1:0] {EMPTY, PEND, FORCE} state_t;

  state_t           state;
  logic [4:0]       rd_mem   [DEPTH];
  logic [N-1:0]     data_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [AGE_W-1:0] age;
  logic             pw, not_empty, grant_fifo, push, pop;

  assign fifo_cnt = cnt;

  always_comb begin
    not_empty  = (cnt != '0);
    pw         = pipe_wr_en & (pipe_rd != 5'd0) & ~stall_req;
    // A forced cycle always takes the head; otherwise the head only fills idle slots
    grant_fifo = not_empty & (stall_req | ~pw);
    lu_ready   = ~rst & (cnt < FULL_CNT);
    push       = lu_valid & lu_ready & (lu_rd != 5'd0);
    pop        = ~rst & grant_fifo;
    cnt_nxt    = cnt + CNT_W'(push) - CNT_W'(pop);

    rf_wr_en = 1'b0;
    rf_rd    = '0;
    rf_data  = '0;
    if (!rst) begin
      if (grant_fifo) begin
        rf_wr_en = 1'b1;
        rf_rd    = rd_mem[rd_ptr];
        rf_data  = data_mem[rd_ptr];
      end else if (pw) begin
        rf_wr_en = 1'b1;
        rf_rd    = pipe_rd;
        rf_data  = pipe_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= lu_rd;
      data_mem[wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      stall_req <= 1'b0;
      cnt       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      age       <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (pop || !not_empty)
        age <= '0;
      else if (age != AGE_MAX)
        age <= age + AGE_W'(1);

      case (state)
        EMPTY: begin
          stall_req <= 1'b0;
          if (cnt_nxt != '0) state <= PEND;
        end
        PEND: begin
          if (pop && cnt_nxt == '0) begin
            state <= EMPTY;
          end else if (!grant_fifo && age == AGE_TRIG) begin
            state     <= FORCE;
            stall_req <= 1'b1;
          end
        end
        FORCE: begin
          stall_req <= 1'b0;
          state     <= (cnt_nxt == '0) ? EMPTY : PEND;
        end
        default: begin
          stall_req <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule
